// File: rtl/sddt_rdata_checker_if.sv
// SDDT read-data AXI-Stream bundle between the read-data FIFO (master) and
// the read-data checker (slave).
//   tdata  : DATA_WIDTH read data, 32-bit lanes
//   tkeep  : byte keep, expected all ones on every beat
//   tlast  : last flag, expected 1 on every beat
//   tvalid : beat valid from the source
//   tready : backpressure from the checker
interface sddt_rdata_checker_if #(
    parameter int DATA_WIDTH = 512
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/sddt_rdata_checker.sv
// SDDT read-data checker: consumes 512-bit read beats with programmable
// backpressure, compares each beat against a seeded constant or incrementing
// pattern, checks per-beat framing and reports run statistics.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle pulse arming a run (honoured in IDLE/DONE)
//   expect_beats    : beats expected in the run, sampled on start
//   seed, mode      : pattern seed and mode (0 constant, 1 incrementing)
//   stall_mask      : 8-phase backpressure mask, bit set = tready low
//   s_axis          : read-data stream (slave side)
//   busy / done     : run in progress / run finished
//   pass            : done with no errors and no timeout
//   timeout         : run ended by the idle timeout
//   beat_count      : beats accepted and checked this run
//   err_count       : erroneous beats, saturating
//   first_err_beat  : index of the first erroneous beat
//   first_err_lanes : lane mismatch mask of that beat (all ones on framing)
//
// state  | meaning
// IDLE   | waiting for start, tready low
// RUN    | accepting and checking beats
// DONE   | run finished, results held until the next start
module sddt_rdata_checker #(
    parameter int DATA_WIDTH     = 512,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [COUNT_WIDTH-1:0]   expect_beats,
    input  logic [31:0]              seed,
    input  logic                     mode,
    input  logic [7:0]               stall_mask,
    sddt_rdata_checker_if.slave      s_axis,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [COUNT_WIDTH-1:0]   beat_count,
    output logic [COUNT_WIDTH-1:0]   err_count,
    output logic [COUNT_WIDTH-1:0]   first_err_beat,
    output logic [DATA_WIDTH/32-1:0] first_err_lanes
);
    localparam int LANES = DATA_WIDTH / 32;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state_q, state_d;

    logic [COUNT_WIDTH-1:0] cfg_expect_q;
    logic [31:0]            cfg_seed_q;
    logic                   cfg_mode_q;
    logic [7:0]             cfg_stall_q;

    logic [2:0]             phase_q;
    logic [COUNT_WIDTH-1:0] acc_count_q;
    logic [TO_W-1:0]        to_cnt_q;

    logic                   p_valid_q;
    logic [COUNT_WIDTH-1:0] p_idx_q;
    logic [LANES-1:0]       p_lane_mis_q;
    logic                   p_frame_err_q;

    logic [COUNT_WIDTH-1:0] beat_count_q;
    logic [COUNT_WIDTH-1:0] err_count_q;
    logic [COUNT_WIDTH-1:0] first_err_beat_q;
    logic [LANES-1:0]       first_err_lanes_q;
    logic                   timeout_q;

    logic             tready_c;
    logic             accept;
    logic             start_arm;
    logic             final_commit;
    logic             to_hit;
    logic             p_err;
    logic             frame_err;
    logic [31:0]      pat_base;
    logic [LANES-1:0] lane_mis;

    // acc_count reaching cfg_expect drops tready the cycle after the final
    // acceptance, before the final commit moves the FSM to DONE.
    assign tready_c  = (state_q == S_RUN) && !cfg_stall_q[phase_q] &&
                       (acc_count_q != cfg_expect_q);
    assign accept    = tready_c && s_axis.tvalid;
    assign start_arm = start && (state_q != S_RUN);

    assign pat_base  = cfg_seed_q + 32'(acc_count_q) * 32'(LANES);

    always_comb begin
        lane_mis = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_mis[k] = s_axis.tdata[k*32 +: 32] !=
                          (cfg_mode_q ? pat_base + 32'(k) : cfg_seed_q);
        end
    end

    assign frame_err    = (s_axis.tkeep != '1) || !s_axis.tlast;
    assign p_err        = p_frame_err_q || (|p_lane_mis_q);
    assign final_commit = p_valid_q && ((p_idx_q + COUNT_WIDTH'(1)) == cfg_expect_q);
    // An accepted beat clears the counter, so a final beat accepted on the
    // would-be timeout cycle always wins.
    assign to_hit       = (state_q == S_RUN) && !accept &&
                          (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = (expect_beats == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (final_commit || to_hit) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_expect_q      <= '0;
            cfg_seed_q        <= '0;
            cfg_mode_q        <= 1'b0;
            cfg_stall_q       <= '0;
            phase_q           <= '0;
            acc_count_q       <= '0;
            to_cnt_q          <= '0;
            p_valid_q         <= 1'b0;
            p_idx_q           <= '0;
            p_lane_mis_q      <= '0;
            p_frame_err_q     <= 1'b0;
            beat_count_q      <= '0;
            err_count_q       <= '0;
            first_err_beat_q  <= '0;
            first_err_lanes_q <= '0;
            timeout_q         <= 1'b0;
        end else begin
            p_valid_q <= accept;
            if (accept) begin
                p_idx_q       <= acc_count_q;
                p_lane_mis_q  <= lane_mis;
                p_frame_err_q <= frame_err;
                acc_count_q   <= acc_count_q + COUNT_WIDTH'(1);
            end

            if (state_q == S_RUN) begin
                phase_q  <= phase_q + 3'd1;
                to_cnt_q <= accept ? '0 : to_cnt_q + TO_W'(1);
                if (to_hit && !final_commit) timeout_q <= 1'b1;
            end

            if (p_valid_q) begin
                beat_count_q <= beat_count_q + COUNT_WIDTH'(1);
                if (p_err) begin
                    if (err_count_q != '1) err_count_q <= err_count_q + COUNT_WIDTH'(1);
                    if (err_count_q == '0) begin
                        first_err_beat_q  <= p_idx_q;
                        first_err_lanes_q <= p_frame_err_q ? '1 : p_lane_mis_q;
                    end
                end
            end

            if (start_arm) begin
                cfg_expect_q      <= expect_beats;
                cfg_seed_q        <= seed;
                cfg_mode_q        <= mode;
                cfg_stall_q       <= stall_mask;
                phase_q           <= '0;
                acc_count_q       <= '0;
                to_cnt_q          <= '0;
                p_valid_q         <= 1'b0;
                beat_count_q      <= '0;
                err_count_q       <= '0;
                first_err_beat_q  <= '0;
                first_err_lanes_q <= '0;
                timeout_q         <= 1'b0;
            end
        end
    end

    assign s_axis.tready   = tready_c;
    assign busy            = (state_q == S_RUN);
    assign done            = (state_q == S_DONE);
    assign pass            = done && (err_count_q == '0) && !timeout_q;
    assign timeout         = timeout_q;
    assign beat_count      = beat_count_q;
    assign err_count       = err_count_q;
    assign first_err_beat  = first_err_beat_q;
    assign first_err_lanes = first_err_lanes_q;
endmodule

// File: tb/tb_sddt_rdata_checker.sv
module tb_sddt_rdata_checker;
    localparam int DW  = 512;
    localparam int CW  = 16;
    localparam int TO  = 16;
    localparam int LN  = DW / 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] expect_beats;
    logic [31:0]   seed;
    logic          mode;
    logic [7:0]    stall_mask;
    logic          busy, done, pass, timeout;
    logic [CW-1:0] beat_count, err_count, first_err_beat;
    logic [LN-1:0] first_err_lanes;

    sddt_rdata_checker_if #(.DATA_WIDTH(DW)) s_axis_if ();

    sddt_rdata_checker #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .expect_beats    (expect_beats),
        .seed            (seed),
        .mode            (mode),
        .stall_mask      (stall_mask),
        .s_axis          (s_axis_if.slave),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .timeout         (timeout),
        .beat_count      (beat_count),
        .err_count       (err_count),
        .first_err_beat  (first_err_beat),
        .first_err_lanes (first_err_lanes)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mode;
        logic [31:0] seed;
        int          n;
        int          nsend;
        logic [7:0]  stall;
        int          lane_beat;
        int          lane;
        int          last0_beat;
        int          keep_beat;
        int          e_beats;
        int          e_err;
        int          e_first_beat;
        logic [15:0] e_first_lanes;
        bit          e_pass;
        bit          e_timeout;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] mask;
        bit          err;
    } sb_t;

    vec_t vecs[8];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input vec_t v, input int i);
        logic [DW-1:0] d;
        logic [31:0]   lane;
        d = '0;
        for (int k = 0; k < LN; k++) begin
            lane = v.mode ? v.seed + 32'(16 * i + k) : v.seed;
            if (i == v.lane_beat && k == v.lane) lane = 32'h0;
            d[k*32 +: 32] = lane;
        end
        return d;
    endfunction

    function automatic logic [15:0] mask_of(input vec_t v, input int i);
        if (i == v.last0_beat || i == v.keep_beat) return 16'hFFFF;
        if (i == v.lane_beat) return 16'(1) << v.lane;
        return 16'h0;
    endfunction

    task automatic drive_beat(input vec_t v, input int i, input bit valid);
        logic [DW/8-1:0] keep;
        keep = '1;
        if (i == v.keep_beat) keep[7] = 1'b0;
        s_axis_if.tdata  = beat_data(v, i);
        s_axis_if.tkeep  = keep;
        s_axis_if.tlast  = (i != v.last0_beat);
        s_axis_if.tvalid = valid;
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int        idx, acc_n, final_cyc, last_acc, done_cyc, prev_bc;
        int        m_beat, m_err, m_fb;
        logic [15:0] m_fl;
        bit        got_done, acc, exp_rdy;
        sb_t       e;
        string     tag;
        tag = $sformatf("v%0d", vi);
        @(posedge clk); #1;
        mode = v.mode; seed = v.seed; expect_beats = CW'(v.n); stall_mask = v.stall;
        start = 1'b1;
        drive_beat(v, 0, v.nsend > 0);
        @(posedge clk); #1;
        start = 1'b0;
        sb.delete();
        idx = 0; acc_n = 0; final_cyc = -1; last_acc = -1; done_cyc = -1; prev_bc = 0;
        m_beat = 0; m_err = 0; m_fb = 0; m_fl = '0; got_done = 0;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                chk({tag, "_clr_beats"}, beat_count, 0);
                chk({tag, "_clr_err"}, err_count, 0);
                chk({tag, "_clr_timeout"}, timeout, 0);
            end
            if (int'(beat_count) != prev_bc) begin
                if (sb.size() == 0) begin
                    chk({tag, "_sb_underflow"}, beat_count, prev_bc);
                end else begin
                    e = sb.pop_front();
                    m_beat++;
                    if (e.err) begin
                        if (m_err == 0) begin m_fb = e.idx; m_fl = e.mask; end
                        m_err++;
                    end
                    chk({tag, "_sb_beats"}, beat_count, m_beat);
                    chk({tag, "_sb_err"}, err_count, m_err);
                    if (m_err > 0) begin
                        chk({tag, "_sb_first_beat"}, first_err_beat, m_fb);
                        chk({tag, "_sb_first_lanes"}, first_err_lanes, m_fl);
                    end
                end
                prev_bc = int'(beat_count);
            end
            exp_rdy = (v.n > 0) && (acc_n < v.n) && !v.stall[cyc % 8] && !(v.e_timeout && done);
            chk({tag, "_tready"}, s_axis_if.tready, exp_rdy);
            acc = s_axis_if.tvalid && s_axis_if.tready;
            if (acc) begin
                if (idx >= v.n) chk({tag, "_extra_beat"}, idx, v.n - 1);
                e.idx = idx; e.mask = mask_of(v, idx); e.err = (e.mask != 0);
                sb.push_back(e);
                if (idx == v.n - 1) final_cyc = cyc;
                last_acc = cyc;
                acc_n++;
            end
            if (final_cyc >= 0 && cyc == final_cyc + 1) chk({tag, "_done_early"}, done, 0);
            if (final_cyc >= 0 && cyc == final_cyc + 2) chk({tag, "_done_latency"}, done, 1);
            if (v.n == 0 && cyc == 0) chk({tag, "_zero_done"}, done, 1);
            if (done) begin got_done = 1; done_cyc = cyc; end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                drive_beat(v, idx, (idx < v.nsend) || (v.nsend == v.n && v.n > 0));
            end
        end
        if (!got_done) chk({tag, "_wait_done_budget"}, 0, 1);
        if (v.e_timeout) chk({tag, "_timeout_latency"}, done_cyc - last_acc, 17);
        chk({tag, "_beats"}, beat_count, v.e_beats);
        chk({tag, "_err"}, err_count, v.e_err);
        chk({tag, "_first_beat"}, first_err_beat, v.e_first_beat);
        chk({tag, "_first_lanes"}, first_err_lanes, v.e_first_lanes);
        chk({tag, "_pass"}, pass, v.e_pass);
        chk({tag, "_timeout"}, timeout, v.e_timeout);
        chk({tag, "_sb_left"}, sb.size(), 0);
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            chk({tag, "_hold_tready"}, s_axis_if.tready, 0);
            chk({tag, "_hold_beats"}, beat_count, v.e_beats);
            chk({tag, "_hold_done"}, done, 1);
        end
        s_axis_if.tvalid = 1'b0;
    endtask

    initial begin
        //           mode seed          n nsend stall  lb ln  l0  kb  beats err fb lanes    pass to
        vecs[0] = '{1'b1, 32'h0000_1000, 4, 4, 8'h00, -1, 0, -1, -1, 4, 0, 0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 32'hA5A5_A5A5, 3, 3, 8'h00,  1, 5, -1, -1, 3, 1, 1, 16'h0020, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_2000, 3, 3, 8'h00, -1, 0,  0,  2, 3, 2, 0, 16'hFFFF, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'hDEAD_0000, 8, 8, 8'hAA, -1, 0, -1, -1, 8, 0, 0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0010, 5, 2, 8'h00, -1, 0, -1, -1, 2, 0, 0, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 32'h1234_5678, 1, 1, 8'h00, -1, 0, -1, -1, 1, 0, 0, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 32'hFFFF_FFF0, 2, 2, 8'h00,  1, 15, -1, -1, 2, 1, 1, 16'h8000, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'h0000_0000, 0, 0, 8'h00, -1, 0, -1, -1, 0, 0, 0, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; expect_beats = '0; seed = '0; mode = 1'b0; stall_mask = '0;
        s_axis_if.tdata = '0; s_axis_if.tkeep = '0; s_axis_if.tlast = 1'b0; s_axis_if.tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", s_axis_if.tready, 0);
        chk("rst_outputs", {busy, done, pass, timeout}, 4'b0);
        chk("rst_counts", {beat_count, err_count, first_err_beat, first_err_lanes}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Mid-run reset: beat 0 repeated with tlast low, so stats are nonzero first.
        @(posedge clk); #1;
        mode = 1'b1; seed = 32'h0000_1000; expect_beats = CW'(4); stall_mask = 8'h00;
        start = 1'b1;
        drive_beat(vecs[2], 0, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_pre_err", err_count, 1);
        chk("midrst_pre_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tready", s_axis_if.tready, 0);
        chk("midrst_outputs", {busy, done, pass, timeout}, 4'b0);
        chk("midrst_counts", {beat_count, err_count, first_err_beat, first_err_lanes}, 64'h0);
        s_axis_if.tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finished");
        $fatal(1, "time limit");
    end
endmodule
